// File: rtl/split_head_scheduler_pkg.sv
// Shared types and width helpers for the head-split scheduler.
package split_head_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/split_head_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    id_o,
  output logic               valid_o
);

  int unsigned idx;

  // Scan from the pointer upward, wrapping once; first hit wins.
  always_comb begin
    gnt_o   = '0;
    id_o    = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid_o && req_i[ID_W'(idx)]) begin
        valid_o              = 1'b1;
        gnt_o[ID_W'(idx)]    = 1'b1;
        id_o                 = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/split_head_scheduler.sv
// Round-robin sequencer for the shared head-split unit: grant, load strobe, then
// one head-group beat per downstream acceptance.
module split_head_scheduler
  import split_head_scheduler_pkg::*;
#(
  parameter  int unsigned NUM_REQ         = 3,
  parameter  int unsigned HEAD_NUM        = 12,
  parameter  int unsigned HEADS_PER_GROUP = 4,
  localparam int unsigned GROUPS          = HEAD_NUM / HEADS_PER_GROUP,
  localparam int unsigned GRP_W           = min1_clog2(GROUPS),
  localparam int unsigned ID_W            = min1_clog2(NUM_REQ)
) (
  input  logic               clk_p,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_n,
  output logic [NUM_REQ-1:0] grant_n,
  input  logic               flush_n,
  output logic               split_load_n,
  output logic [ID_W-1:0]    split_sel,
  output logic [GRP_W-1:0]   group_idx,
  output logic               out_valid_n,
  input  logic               out_ready_n,
  output logic [ID_W-1:0]    out_id,
  output logic               out_last,
  output logic               busy
);

  if ((HEADS_PER_GROUP == 0) || ((HEAD_NUM % HEADS_PER_GROUP) != 0) || (NUM_REQ < 1))
  begin : g_bad_cfg
    $error("split_head_scheduler: HEAD_NUM must be a multiple of HEADS_PER_GROUP and NUM_REQ >= 1");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_n_q, grant_n_d;
  logic               split_load_n_q, split_load_n_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [GRP_W-1:0]   group_idx_q, group_idx_d;
  logic               out_valid_n_q, out_valid_n_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_id;
  logic               arb_valid;
  logic [ID_W-1:0]    ptr_after_id;
  logic               last_grp;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i   (~req_n),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .id_o    (arb_id),
    .valid_o (arb_valid)
  );

  assign grant_n      = grant_n_q;
  assign split_load_n = split_load_n_q;
  assign split_sel    = id_q;
  assign out_id       = id_q;
  assign group_idx    = group_idx_q;
  assign out_valid_n  = out_valid_n_q;
  assign out_last     = out_last_q;
  assign busy         = busy_q;

  // Next-state and registered-output values; grant and load strobe are single-cycle pulses.
  always_comb begin
    state_d        = state_q;
    grant_n_d      = '1;
    split_load_n_d = 1'b1;
    id_d           = id_q;
    group_idx_d    = group_idx_q;
    out_valid_n_d  = out_valid_n_q;
    out_last_d     = out_last_q;
    busy_d         = busy_q;
    rr_ptr_d       = rr_ptr_q;

    ptr_after_id = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
    last_grp     = (group_idx_q == GRP_W'(GROUPS - 1));

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d        = ST_LOAD;
          grant_n_d      = ~arb_gnt;
          split_load_n_d = 1'b0;
          id_d           = arb_id;
          group_idx_d    = '0;
          out_last_d     = 1'b0;
          busy_d         = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!flush_n) begin
          state_d       = ST_IDLE;
          out_valid_n_d = 1'b1;
          out_last_d    = 1'b0;
          busy_d        = 1'b0;
          rr_ptr_d      = ptr_after_id;
        end else begin
          state_d       = ST_STREAM;
          out_valid_n_d = 1'b0;
          out_last_d    = (GROUPS == 1);
        end
      end
      ST_STREAM: begin
        // Flush wins over a simultaneous acceptance: the beat is not counted.
        if (!flush_n) begin
          state_d       = ST_IDLE;
          out_valid_n_d = 1'b1;
          out_last_d    = 1'b0;
          busy_d        = 1'b0;
          rr_ptr_d      = ptr_after_id;
        end else if (!out_ready_n) begin
          if (last_grp) begin
            state_d       = ST_IDLE;
            out_valid_n_d = 1'b1;
            out_last_d    = 1'b0;
            busy_d        = 1'b0;
            rr_ptr_d      = ptr_after_id;
          end else begin
            group_idx_d = group_idx_q + 1'b1;
            out_last_d  = (group_idx_q == GRP_W'(GROUPS - 2));
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      grant_n_q      <= '1;
      split_load_n_q <= 1'b1;
      id_q           <= '0;
      group_idx_q    <= '0;
      out_valid_n_q  <= 1'b1;
      out_last_q     <= 1'b0;
      busy_q         <= 1'b0;
      rr_ptr_q       <= '0;
    end else begin
      state_q        <= state_d;
      grant_n_q      <= grant_n_d;
      split_load_n_q <= split_load_n_d;
      id_q           <= id_d;
      group_idx_q    <= group_idx_d;
      out_valid_n_q  <= out_valid_n_d;
      out_last_q     <= out_last_d;
      busy_q         <= busy_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_split_head_scheduler.sv
// Directed bench for split_head_scheduler: default config plus a one-group config.
module tb_split_head_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] req_n, grant_n;
  logic       flush_n, split_load_n, out_valid_n, out_ready_n, out_last, busy;
  logic [1:0] split_sel, group_idx, out_id;

  logic [2:0] req2_n, grant2_n;
  logic       flush2_n, split_load2_n, out_valid2_n, out_ready2_n, out_last2, busy2;
  logic [1:0] split_sel2, out_id2;
  logic [0:0] group_idx2;

  int checks   = 0;
  int failures = 0;

  split_head_scheduler #(
    .NUM_REQ         (3),
    .HEAD_NUM        (12),
    .HEADS_PER_GROUP (4)
  ) dut (
    .clk_p        (clk),
    .rst_n        (rst_n),
    .req_n        (req_n),
    .grant_n      (grant_n),
    .flush_n      (flush_n),
    .split_load_n (split_load_n),
    .split_sel    (split_sel),
    .group_idx    (group_idx),
    .out_valid_n  (out_valid_n),
    .out_ready_n  (out_ready_n),
    .out_id       (out_id),
    .out_last     (out_last),
    .busy         (busy)
  );

  split_head_scheduler #(
    .NUM_REQ         (3),
    .HEAD_NUM        (12),
    .HEADS_PER_GROUP (12)
  ) dut_g1 (
    .clk_p        (clk),
    .rst_n        (rst_n),
    .req_n        (req2_n),
    .grant_n      (grant2_n),
    .flush_n      (flush2_n),
    .split_load_n (split_load2_n),
    .split_sel    (split_sel2),
    .group_idx    (group_idx2),
    .out_valid_n  (out_valid2_n),
    .out_ready_n  (out_ready2_n),
    .out_id       (out_id2),
    .out_last     (out_last2),
    .busy         (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant_n"}, grant_n, 3'b111);
    chk({tag, "_split_load_n"}, split_load_n, 1'b1);
    chk({tag, "_out_valid_n"}, out_valid_n, 1'b1);
    chk({tag, "_split_sel"}, split_sel, 2'd0);
    chk({tag, "_out_id"}, out_id, 2'd0);
    chk({tag, "_group_idx"}, group_idx, 2'd0);
    chk({tag, "_out_last"}, out_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Request already driven; one edge later the LOAD cycle must be visible.
  task automatic expect_grant(input int id, input string tag);
    logic [2:0] e;
    e = ~(3'b001 << id);
    tick();
    chk({tag, "_grant_n"}, grant_n, e);
    chk({tag, "_split_load_n"}, split_load_n, 1'b0);
    chk({tag, "_split_sel"}, split_sel, id);
    chk({tag, "_out_id"}, out_id, id);
    chk({tag, "_busy"}, busy, 1'b1);
  endtask

  // Three unimpeded beats, then back to idle.
  task automatic expect_beats(input int id, input string tag);
    for (int g = 0; g < 3; g++) begin
      tick();
      chk({tag, "_valid"}, out_valid_n, 1'b0);
      chk({tag, "_group_idx"}, group_idx, g);
      chk({tag, "_last"}, out_last, (g == 2));
      chk({tag, "_beat_id"}, out_id, id);
      chk({tag, "_grant_released"}, grant_n, 3'b111);
      chk({tag, "_load_released"}, split_load_n, 1'b1);
    end
    tick();
    chk({tag, "_end_valid"}, out_valid_n, 1'b1);
    chk({tag, "_end_busy"}, busy, 1'b0);
    chk({tag, "_end_last"}, out_last, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    req_n        = 3'b111;
    flush_n      = 1'b1;
    out_ready_n  = 1'b0;
    req2_n       = 3'b111;
    flush2_n     = 1'b1;
    out_ready2_n = 1'b0;

    #12;
    chk_reset_vals("reset");
    chk("reset_g1_last", out_last2, 1'b0);
    chk("reset_g1_valid", out_valid2_n, 1'b1);
    rst_n = 1'b1;

    // All three requesting continuously: service order 0,1,2,0.
    req_n = 3'b000;
    for (int j = 0; j < 4; j++) begin
      expect_grant(j % 3, "rr");
      if (j == 3) req_n = 3'b111;
      expect_beats(j % 3, "rr");
    end

    // Single requester 0 (pointer now 1, wraps to 0).
    req_n = 3'b110;
    expect_grant(0, "single");
    req_n = 3'b111;
    expect_beats(0, "single");

    // Backpressure at group 1 for four cycles.
    req_n = 3'b101;
    expect_grant(1, "bp");
    req_n = 3'b111;
    tick();
    chk("bp_idx0", group_idx, 2'd0);
    tick();
    chk("bp_idx1", group_idx, 2'd1);
    out_ready_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_hold_idx", group_idx, 2'd1);
      chk("bp_hold_valid", out_valid_n, 1'b0);
      chk("bp_hold_id", out_id, 2'd1);
      chk("bp_hold_last", out_last, 1'b0);
    end
    out_ready_n = 1'b0;
    tick();
    chk("bp_idx2", group_idx, 2'd2);
    chk("bp_last", out_last, 1'b1);
    tick();
    chk("bp_done_valid", out_valid_n, 1'b1);
    chk("bp_done_busy", busy, 1'b0);

    // Flush on the group-1 beat while it is being accepted (pointer now 2).
    req_n = 3'b110;
    expect_grant(0, "fl");
    req_n = 3'b111;
    tick();
    chk("fl_idx0", group_idx, 2'd0);
    tick();
    chk("fl_idx1", group_idx, 2'd1);
    flush_n = 1'b0;
    tick();
    chk("fl_valid", out_valid_n, 1'b1);
    chk("fl_busy", busy, 1'b0);
    chk("fl_no_advance", group_idx, 2'd1);
    chk("fl_last", out_last, 1'b0);
    flush_n = 1'b1;
    req_n   = 3'b000;
    expect_grant(1, "fl_next");
    req_n = 3'b111;
    tick();
    chk("fl_next_valid", out_valid_n, 1'b0);
    chk("fl_next_idx", group_idx, 2'd0);

    // Asynchronous reset in the middle of streaming.
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    #2;
    rst_n = 1'b1;
    req_n = 3'b000;
    expect_grant(0, "postrst");
    req_n = 3'b111;
    expect_beats(0, "postrst");

    // One group per job: single beat with out_last set.
    req2_n = 3'b011;
    tick();
    chk("g1_grant_n", grant2_n, 3'b011);
    chk("g1_load", split_load2_n, 1'b0);
    chk("g1_id", out_id2, 2'd2);
    req2_n = 3'b111;
    tick();
    chk("g1_valid", out_valid2_n, 1'b0);
    chk("g1_last", out_last2, 1'b1);
    chk("g1_idx", group_idx2, 1'b0);
    tick();
    chk("g1_end_valid", out_valid2_n, 1'b1);
    chk("g1_end_busy", busy2, 1'b0);
    chk("g1_end_last", out_last2, 1'b0);
    req2_n = 3'b110;
    tick();
    chk("g1b_grant_n", grant2_n, 3'b110);
    req2_n = 3'b111;
    tick();
    chk("g1b_valid", out_valid2_n, 1'b0);
    chk("g1b_last", out_last2, 1'b1);
    chk("g1b_id", out_id2, 2'd0);
    tick();
    chk("g1b_end_valid", out_valid2_n, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/split_head_scheduler.md
# split_head_scheduler

Sequencer and arbiter for the shared head-split datapath in the attention front end. Up to NUM_REQ producers (Q, K, V projection outputs by default) request the single split unit; the block grants one requester round-robin, pulses the split unit's load strobe, then steps the head-group index once per downstream acceptance until all groups have been emitted. Sits between the projection stage and the per-head attention engine.

## Interface
- NUM_REQ, 3, number of requesters sharing the split unit
- HEAD_NUM, 12, total attention heads
- HEADS_PER_GROUP, 4, heads emitted per output beat (split OUTPUT_SHAPE_2)
- GROUPS, HEAD_NUM/HEADS_PER_GROUP, beats per split job (derived localparam)
- GRP_W, clog2(GROUPS) min 1, group index width (derived localparam)
- ID_W, clog2(NUM_REQ) min 1, requester id width (derived localparam)

- clk_p  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_n  in  NUM_REQ  per-requester job request, active-low, level, held until granted
- grant_n  out  NUM_REQ  one-hot-low grant pulse, one cycle
- flush_n  in  1  synchronous abort of current job, active-low
- split_load_n  out  1  to split unit input_valid_n; low one cycle to capture selected matrix
- split_sel  out  ID_W  requester mux select for split unit matrix input
- group_idx  out  GRP_W  head-group index presented to split unit
- out_valid_n  out  1  current group beat valid, active-low
- out_ready_n  in  1  downstream accepts beat, active-low
- out_id  out  ID_W  requester id owning current beat
- out_last  out  1  current beat is group GROUPS-1
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states IDLE, LOAD, STREAM.
- IDLE: if any req_n bit low, pick first low bit at or after rr_ptr (wrapping); register id into split_sel/out_id, drive that grant_n bit low for the next cycle, go LOAD. Else stay.
- LOAD (one cycle): split_load_n=0, grant_n[id]=0, group_idx=0; go STREAM.
- STREAM: out_valid_n=0. Beat accepted when out_valid_n=0 and out_ready_n=0. On acceptance: if group_idx==GROUPS-1 go IDLE, rr_ptr<=id+1 (wrap at NUM_REQ); else group_idx+1. No acceptance: hold all outputs.
- flush_n=0 in LOAD or STREAM: go IDLE next cycle, no beat counted, rr_ptr<=id+1. flush_n ignored in IDLE. Flush has priority over acceptance in the same cycle.
- Requesters must release req_n after the grant pulse; a request still low in IDLE is treated as a new job.
- GROUPS==1: single beat per job, out_last constantly 1 in STREAM.
- Elaboration error if HEAD_NUM % HEADS_PER_GROUP != 0 or NUM_REQ < 1.

## Timing
- All outputs registered. Reset values: state IDLE, grant_n all 1, split_load_n 1, out_valid_n 1, split_sel 0, out_id 0, group_idx 0, out_last 0 (1 if GROUPS==1 after LOAD only), busy 0, rr_ptr 0.
- Request seen low at edge t -> grant_n/split_load_n low during cycle t+1 -> out_valid_n low from t+2 (split unit output valid same cycle as its registered data).
- Job with no backpressure: GROUPS+2 cycles request-to-IDLE; minimum one IDLE cycle between jobs (back-to-back throughput GROUPS+2 cycles/job).
- Reset mid-job: all outputs return to reset values asynchronously; partially streamed job is lost.

## Structure
- Shared package: state enum (IDLE/LOAD/STREAM), derived-width helper for GRP_W/ID_W.
- One sub-module: rr_arbiter (NUM_REQ requests, pointer in, one-hot grant and id out, combinational); FSM, counters and output registers in top.

## Test plan
- Single job, req_n=3'b110, out_ready_n=0 always -> grant_n=3'b110 one cycle, split_load_n pulse, group_idx 0,1,2 on consecutive beats, out_last on idx 2, busy low after 5 cycles.
- Backpressure: out_ready_n high for 4 cycles at group 1 -> group_idx, out_id, out_valid_n held stable; job completes 4 cycles later.
- Simultaneous req_n=3'b000 held for three jobs -> grants served in order 0,1,2, then 0 again.
- flush_n low on group 1 beat with out_ready_n low -> no advance, IDLE next cycle, next grant goes to id+1.
- rst_n low during STREAM -> outputs at reset values immediately; after release, fresh request restarts at group 0 with rr_ptr 0.
- HEADS_PER_GROUP=12 (GROUPS=1) -> exactly one beat with out_last=1 per job.
